// File: rtl/i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_pkg : frame constants and sample types shared by the I2S tx/rx   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;

  typedef logic [23:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  // Counter width that stays legal for a divide-by-one configuration.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_clkgen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_tx_clkgen : BCK divider with a strobe for the BCK falling edge   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_tx_clkgen
  import i2s_pkg::*;
#(
  parameter int BCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic o_bck,
  output logic o_fall_stb
);

  localparam int CW = cnt_width(BCK_DIV);

  logic [CW-1:0] r_div_cnt;
  logic          r_bck;
  logic          w_wrap;

  assign w_wrap = (r_div_cnt == CW'(BCK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_bck     <= ~r_bck;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // High in the cycle whose closing edge drives bck from 1 to 0.
  assign o_fall_stb = w_wrap & r_bck;
  assign o_bck      = r_bck;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_tx : 24-bit stereo I2S transmitter with valid/ready sample input |
// | Option : define I2S_TX_LJ_EN for left-justified data alignment       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCK_DIV = 2,
  parameter int WIDTH   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             mclk,
  output logic             bck,
  output logic             lrck,
  output logic             sdata,
  output logic             frame_start,
  output logic             underrun
);

  localparam int         CNT_W   = $clog2(FRAME_BITS);
  localparam logic [5:0] C_WIDTH = 6'(WIDTH);

  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_lrck;
  logic             r_sdata;
  logic             r_ready;
  logic             r_frame_start;
  logic             r_underrun;
  logic [WIDTH-1:0] r_hold_l, r_hold_r;
  logic [WIDTH-1:0] r_shad_l, r_shad_r;

  logic             w_bck;
  logic             w_fall;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_shad_l_nxt, w_shad_r_nxt;
  logic [WIDTH-1:0] w_word;
  logic [4:0]       w_pos;
  logic [4:0]       w_idx;
  logic             w_bit;

  i2s_tx_clkgen #(
    .BCK_DIV (BCK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .o_bck      (w_bck),
    .o_fall_stb (w_fall)
  );

  assign w_cnt_nxt = r_bit_cnt + 1'b1;
  assign w_load    = w_fall && (w_cnt_nxt == '0);
  assign w_accept  = sample_valid && r_ready;

  // Holding empty at the load edge transmits silence, even if a pair is
  // being accepted in the very same cycle.
  assign w_shad_l_nxt = w_load ? (r_ready ? '0 : r_hold_l) : r_shad_l;
  assign w_shad_r_nxt = w_load ? (r_ready ? '0 : r_hold_r) : r_shad_r;

  assign w_pos  = w_cnt_nxt[4:0];
  assign w_word = (w_cnt_nxt >= CNT_W'(SLOT_BITS)) ? w_shad_r_nxt : w_shad_l_nxt;

`ifdef I2S_TX_LJ_EN
  assign w_idx = 5'(WIDTH - 1) - w_pos;
  always_comb begin
    w_bit = 1'b0;
    if ({1'b0, w_pos} < C_WIDTH) w_bit = w_word[w_idx];
  end
`else
  assign w_idx = 5'(WIDTH) - w_pos;
  always_comb begin
    w_bit = 1'b0;
    if ((w_pos != 5'd0) && ({1'b0, w_pos} <= C_WIDTH)) w_bit = w_word[w_idx];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= '1;
      r_lrck        <= 1'b1;
      r_sdata       <= 1'b0;
      r_ready       <= 1'b1;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_shad_l      <= '0;
      r_shad_r      <= '0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load & r_ready;
      r_shad_l      <= w_shad_l_nxt;
      r_shad_r      <= w_shad_r_nxt;
      if (w_fall) begin
        r_bit_cnt <= w_cnt_nxt;
        r_lrck    <= (w_cnt_nxt >= CNT_W'(SLOT_BITS));
        r_sdata   <= w_bit;
      end
      if (w_accept) begin
        r_hold_l <= left;
        r_hold_r <= right;
        r_ready  <= 1'b0;
      end else if (w_load) begin
        r_ready  <= 1'b1;
      end
    end
  end

  assign mclk         = clk;
  assign bck          = w_bck;
  assign lrck         = r_lrck;
  assign sdata        = r_sdata;
  assign sample_ready = r_ready;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2s_tx : directed self-checking bench for i2s_tx                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2s_tx;

  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] left = '0;
  logic [WIDTH-1:0] right = '0;
  logic             sample_valid = 1'b0;
  logic             sample_ready, mclk, bck, lrck, sdata, frame_start, underrun;

  int k;
  int checks = 0;
  int failures = 0;

  // Per-frame expected words and whether that frame's load is an underrun.
  logic [WIDTH-1:0] fl [4];
  logic [WIDTH-1:0] fr [4];
  logic             fu [4];

  i2s_tx #(
    .BCK_DIV (2),
    .WIDTH   (WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .left         (left),
    .right        (right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mclk         (mclk),
    .bck          (bck),
    .lrck         (lrck),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // k = number of clk edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  function automatic logic exp_bit(input int b, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    int p;
    logic [WIDTH-1:0] w;
    p = b % 32;
    w = (b >= 32) ? r : l;
`ifdef I2S_TX_LJ_EN
    if (p < WIDTH) return w[WIDTH-1-p];
`else
    if (p >= 1 && p <= WIDTH) return w[WIDTH-p];
`endif
    return 1'b0;
  endfunction

  // Expected {bck, lrck, sdata, frame_start, underrun} after edge kk.
  function automatic logic [4:0] exp_outs(input int kk);
    int   b, f;
    logic fs, bk;
    bk = 1'((kk >> 1) & 1);
    if (kk < 4) return {bk, 1'b1, 3'b000};
    b  = ((kk - 4) / 4) % 64;
    f  = (kk - 4) / 256;
    fs = (((kk - 4) % 256) == 0);
    return {bk, (b >= 32), exp_bit(b, fl[f], fr[f]), fs, fs & fu[f]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    left = '0;
    right = '0;
    for (int i = 0; i < 4; i++) begin
      fl[i] = '0;
      fr[i] = '0;
      fu[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bck, lrck, sdata, sample_ready, frame_start, underrun} !== 6'b010100) begin
      failures++;
      $display("FAIL reset_values got=%b want=010100", {bck, lrck, sdata, sample_ready, frame_start, underrun});
    end
    checks++;
    if (mclk !== clk) begin
      failures++;
      $display("FAIL mclk_copy got=%b want=%b", mclk, clk);
    end
  endtask

  task automatic test_idle();
    do_reset();
    while (k < 600) begin
      @(posedge clk); #1;
      checks++;
      if ({bck, lrck, sdata, frame_start, underrun} !== exp_outs(k)) begin
        failures++;
        $display("FAIL idle k=%0d got=%b want=%b", k, {bck, lrck, sdata, frame_start, underrun}, exp_outs(k));
      end
      checks++;
      if (sample_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_ready k=%0d got=%b want=1", k, sample_ready);
      end
    end
  endtask

  task automatic test_pattern();
    logic prev;
    do_reset();
    fl[0] = 24'hA5A5A5; fr[0] = 24'h5A5A5A; fu[0] = 1'b0;
    left = 24'hA5A5A5; right = 24'h5A5A5A; sample_valid = 1'b1;
    prev = 1'b0;
    while (k < 520) begin
      @(posedge clk); #1;
      if (k == 1) begin
        sample_valid = 1'b0;
        checks++;
        if (sample_ready !== 1'b0) begin
          failures++;
          $display("FAIL pattern_ready_accept got=%b want=0", sample_ready);
        end
      end
      if (k == 4) begin
        checks++;
        if (sample_ready !== 1'b1) begin
          failures++;
          $display("FAIL pattern_ready_load got=%b want=1", sample_ready);
        end
      end
      checks++;
      if ({bck, lrck, sdata, frame_start, underrun} !== exp_outs(k)) begin
        failures++;
        $display("FAIL pattern k=%0d got=%b want=%b", k, {bck, lrck, sdata, frame_start, underrun}, exp_outs(k));
      end
      if (k >= 6 && (k % 4) == 2) begin
        checks++;
        if (sdata !== prev) begin
          failures++;
          $display("FAIL pattern_stable_rise k=%0d got=%b want=%b", k, sdata, prev);
        end
      end
      prev = sdata;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] v [3];
    do_reset();
    v[0] = 24'h000001; v[1] = 24'h800000; v[2] = 24'h7FFFFF;
    for (int i = 0; i < 3; i++) begin
      fl[i] = v[i];
      fr[i] = v[(i + 1) % 3];
      fu[i] = 1'b0;
    end
    left = v[0]; right = v[1]; sample_valid = 1'b1;
    while (k < 800) begin
      @(posedge clk); #1;
      if (k == 1) begin left = v[1]; right = v[2]; end
      if (k == 5) begin left = v[2]; right = v[0]; end
      if (k == 261) sample_valid = 1'b0;
      if (k == 1 || k == 4 || k == 5 || k == 259 || k == 260 || k == 261 || k == 516) begin
        checks++;
        if (sample_ready !== ((k == 4 || k == 260 || k == 516) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL b2b_ready k=%0d got=%b", k, sample_ready);
        end
      end
      checks++;
      if ({bck, lrck, sdata, frame_start, underrun} !== exp_outs(k)) begin
        failures++;
        $display("FAIL b2b k=%0d got=%b want=%b", k, {bck, lrck, sdata, frame_start, underrun}, exp_outs(k));
      end
    end
  endtask

  task automatic test_load_edge();
    do_reset();
    fl[1] = 24'h123456; fr[1] = 24'hFEDCBA; fu[1] = 1'b0;
    while (k < 600) begin
      @(posedge clk); #1;
      if (k == 3) begin
        left = 24'h123456; right = 24'hFEDCBA; sample_valid = 1'b1;
      end
      if (k == 4) begin
        sample_valid = 1'b0;
        checks++;
        if (sample_ready !== 1'b0) begin
          failures++;
          $display("FAIL edge_ready_held got=%b want=0", sample_ready);
        end
      end
      if (k == 260) begin
        checks++;
        if (sample_ready !== 1'b1) begin
          failures++;
          $display("FAIL edge_ready_load got=%b want=1", sample_ready);
        end
      end
      checks++;
      if ({bck, lrck, sdata, frame_start, underrun} !== exp_outs(k)) begin
        failures++;
        $display("FAIL edge k=%0d got=%b want=%b", k, {bck, lrck, sdata, frame_start, underrun}, exp_outs(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fl[0] = 24'hC0FFEE; fr[0] = 24'h0BADF0; fu[0] = 1'b0;
    left = 24'hC0FFEE; right = 24'h0BADF0; sample_valid = 1'b1;
    while (k < 166) begin
      @(posedge clk); #1;
      if (k == 1) begin left = 24'h111111; right = 24'h222222; end
      if (k == 5) sample_valid = 1'b0;
      checks++;
      if ({bck, lrck, sdata, frame_start, underrun} !== exp_outs(k)) begin
        failures++;
        $display("FAIL mid_pre k=%0d got=%b want=%b", k, {bck, lrck, sdata, frame_start, underrun}, exp_outs(k));
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bck, lrck, sdata, sample_ready, frame_start, underrun} !== 6'b010100) begin
      failures++;
      $display("FAIL mid_reset_values got=%b want=010100", {bck, lrck, sdata, sample_ready, frame_start, underrun});
    end
    do_reset();
    while (k < 300) begin
      @(posedge clk); #1;
      checks++;
      if ({bck, lrck, sdata, frame_start, underrun} !== exp_outs(k)) begin
        failures++;
        $display("FAIL mid_post k=%0d got=%b want=%b", k, {bck, lrck, sdata, frame_start, underrun}, exp_outs(k));
      end
      checks++;
      if (sample_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_discard k=%0d got=%b want=1", k, sample_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_pattern();
    test_back_to_back();
    test_load_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S transmitter, the playback-side counterpart of the PCM1808 capture path.
- Takes 24-bit stereo samples through a valid/ready handshake.
- Generates BCK, LRCK and MCLK from the 12 MHz system clock and serialises the samples to an I2S DAC (e.g. PCM5102).
- Sits in top next to the i2s receiver; processed audio from the eq chain feeds it.

Parameters:
- BCK_DIV, 2: BCK half-period in clk cycles. 12 MHz / (2*2) = 3 MHz BCK, fs = 46.875 kHz.
- WIDTH, 24: sample width in bits. Must be <= 31.

Ports:
- clk  in  1  system clock, 12 MHz (256fs).
- reset  in  1  asynchronous, active-high reset.
- left  in  WIDTH  left sample, two's complement.
- right  in  WIDTH  right sample, two's complement.
- sample_valid  in  1  left/right pair offered.
- sample_ready  out  1  holding register empty; pair accepted when valid && ready at posedge clk.
- mclk  out  1  DAC system clock; combinational copy of clk.
- bck  out  1  I2S bit clock.
- lrck  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  I2S serial data.
- frame_start  out  1  one-clk pulse when a new frame is loaded into the shifter.
- underrun  out  1  one-clk pulse when a frame loads with no pending sample.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-high. All outputs are registers except mclk.
- Reset values:
  - bck = 0, lrck = 1, sdata = 0, sample_ready = 1, frame_start = 0, underrun = 0.
  - div_cnt = 0, bit_cnt = 63, holding and shadow registers = 0.
- Divider:
  - div_cnt counts 0..BCK_DIV-1; bck toggles when div_cnt == BCK_DIV-1.
  - fall_stb is asserted in the clk cycle where bck goes 1->0.
  - First rising bck edge is BCK_DIV clks after reset release.
- Frame counter:
  - bit_cnt (6 bits) increments on fall_stb and wraps 63->0. Frame = 64 BCK = 2*BCK_DIV*64 clks.
  - lrck is registered: 0 for bit_cnt 0..31, 1 for 32..63. It changes on BCK falling edges.
- Load at the fall_stb that enters bit_cnt 0:
  - If holding is full: shadow <= holding, holding is emptied (sample_ready = 1 next cycle).
  - If holding is empty: shadow <= 0 and underrun pulses.
  - frame_start pulses in both cases, in the same cycle as the load.
- Serialisation:
  - Slot position p = bit_cnt[4:0]; channel word is left for bit_cnt < 32, right otherwise.
  - For p in 1..WIDTH, sdata = word[WIDTH-p] (MSB one BCK after the LRCK edge); otherwise sdata = 0.
  - sdata updates only on fall_stb, so it is stable across every rising edge.
- Handshake:
  - sample_ready = ~holding_full; capture when valid && ready.
  - Holding cannot be overwritten while full; the producer stalls.
  - Accept and frame load in the same cycle with holding empty: the load sees empty (underrun, zeros transmitted); the accepted pair stays in holding for the next frame.
- Reset mid-frame: all state returns to reset values immediately. Any pending sample is discarded. bck returns low without a glitch pulse; the partial frame is abandoned.
- Latency: a sample accepted before the load edge appears MSB-first 1 BCK after the next LRCK falling edge. The right channel follows 32 BCK later.

Optional Feature:
- Macro: I2S_TX_LJ_EN.
- Defined: left-justified format. sdata = word[WIDTH-1-p] for p in 0..WIDTH-1, so the MSB is coincident with the LRCK edge.
- Not defined: standard I2S one-BCK delay as specified above. Ports and timing are otherwise unchanged.

Decomposition:
- Package i2s_pkg:
  - Constants FRAME_BITS = 64, SLOT_BITS = 32.
  - typedef sample_t = logic [23:0].
  - typedef stereo_t struct {sample_t l, r}.
  - The existing receiver shares this package.
- One sub-module: i2s_tx_clkgen (divider producing bck and fall_stb, parameterised on BCK_DIV). Reusable by the receiver.

Test Plan:
- Reset release, no samples: bck period 4 clks, lrck period 256 clks; underrun pulses every 256 clks; sdata constantly 0.
- Present left=24'hA5A5A5, right=24'h5A5A5A before the first load: left bits appear at bit_cnt 1..24, right at 33..56, zeros elsewhere. sdata is stable on every bck rising edge.
- Producer holds valid high continuously with values 24'h000001, 24'h800000, 24'h7FFFFF: one pair is accepted per frame, ready drops for exactly one frame per pair, no underrun after the first load.
- sample_valid asserted in the exact clk of the load edge with holding empty: underrun = 1, that frame sends zeros, the pair is sent in the following frame.
- Assert reset at bit_cnt = 40 mid-right-slot: all outputs go to reset values within the same cycle; the pending sample is discarded; timing resumes identically to the first test.
- Loopback of sdata/bck/lrck into the i2s receiver: received left/right equal the sent pair one frame later. Repeat with I2S_TX_LJ_EN defined against the expected LJ bit positions.
